// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counting primitives (up/down counter, timers).
package counter_pkg;

  typedef enum logic { CNT_DOWN = 1'b0, CNT_UP = 1'b1 } dir_e;
  typedef enum logic { MODE_WRAP = 1'b0, MODE_SAT = 1'b1 } mode_e;

  // Limits a requested load value to the top of the count range.
  function automatic int unsigned clamp_mod(input int unsigned value, input int unsigned modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: asserts tick (combinational) on every PRESCALE-th enabled cycle.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt;

  assign tick = en & (cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with prescaled enable, clamped load and
// wrap/saturate modes. Define COUNTER_OVF_STICKY_EN to add the sticky ovf flag (ovf_clr/ovf).
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam mode_e            MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

  logic             tick;
  logic             at_end;
  logic             dir_up;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(tick)
  );

  assign dir_up = (dir_e'(up_dn) == CNT_UP);
  assign at_end = dir_up ? (q == QMAX) : (q == '0);
  assign tc     = tick & at_end;

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = WIDTH'(clamp_mod(32'(load_val), MODULUS));
    end else if (tick) begin
      if (!at_end) begin
        q_nxt = dir_up ? q + WIDTH'(1) : q - WIDTH'(1);
      end else if (MODE == MODE_WRAP) begin
        q_nxt    = dir_up ? '0 : QMAX;
        wrap_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  // Any range-end step (wrap or saturate-hold) sets the flag; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (tc && !load) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
